// File: rtl/core_pkg.sv
// Shared core constants: instruction width, NOP encoding and PC step.
// Imported by the fetch unit and by decode.
package core_pkg;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;
endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry prefetch buffer of {pc, instr}. The head is a register, so the
// outputs never depend combinationally on the write data. Flush beats push.
module ifetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 7,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  wr_pc,
    input  logic [INSTR_W-1:0] wr_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [1:0]         count
);

    logic [ADDR_W-1:0]  tail_pc;
    logic [INSTR_W-1:0] tail_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_pc    <= RESET_PC;
            head_instr <= NOP_INSTR;
            tail_pc    <= RESET_PC;
            tail_instr <= NOP_INSTR;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= wr_pc;
                        head_instr <= wr_instr;
                        count      <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail_pc    <= wr_pc;
                        tail_instr <= wr_instr;
                        count      <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        count      <= 2'd1;
                    end else if (count == 2'd1) begin
                        count <= 2'd0;
                    end
                end
                2'b11: begin
                    // Pop on an empty buffer is ignored, so treat it as a plain push.
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= wr_pc;
                        tail_instr <= wr_instr;
                    end else begin
                        head_pc    <= wr_pc;
                        head_instr <= wr_instr;
                        count      <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, imem read port, 2-entry prefetch buffer.
// Optional IFETCH_STALL_CNT_EN adds a saturating decode-stall counter.
module instr_fetch
    import core_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 7,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  r_addr_imem,
    input  logic [INSTR_W-1:0] r_data_imem,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    logic              unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    assign r_addr_imem = pc;
    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    assign push        = !redirect_valid && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    ifetch_fifo #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .wr_pc      (pc),
        .wr_instr   (r_data_imem),
        .head_pc    (instr_pc),
        .head_instr (instr_data),
        .count      (count)
    );

`ifdef IFETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (instr_valid && !instr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
